channel_send: RTL and testbench

- Transmit side of the two-word channel rendezvous protocol.
- Channel layout in RAM: word at `channel` holds the waiting process id (0 = none); word at `channel+1` holds the message.
- If a receiver is already parked on the channel, the block hands the message to it and requests that it be scheduled. Otherwise it parks the message and the sender's pid in the channel, and requests that the sender be descheduled.
- Sits beside the receive block under the process/channel controller and shares its single-port RAM.

---
 rtl/channel_send_pkg.sv | 17 +
 rtl/channel_send_if.sv | 29 ++
 rtl/channel_send.sv | 147 ++++++++++++++
 tb/tb_channel_send.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_send_pkg.sv
// Shared constants for the channel rendezvous blocks: bus widths, RAM access
// modes and the two-word channel layout that send and receive both rely on.
package channel_send_pkg;

    localparam int ADDRESS_BITS = 8;
    localparam int DATA_BITS    = 16;

    localparam logic RAM_READ  = 1'b0;
    localparam logic RAM_WRITE = 1'b1;

    localparam int NO_PROCESS = 0;

    // Word offsets inside a channel: waiting pid first, message second.
    localparam int CHANNEL_PID_OFFSET = 0;
    localparam int CHANNEL_MSG_OFFSET = 1;

endpackage

// File: rtl/channel_send_if.sv
// Single-port RAM bus shared by the channel blocks; the block drives address,
// mode and write data, and the RAM returns read data one cycle later.
interface channel_send_if
    import channel_send_pkg::*;
#(
    parameter int addrBits = ADDRESS_BITS,
    parameter int dataBits = DATA_BITS
);

    logic [addrBits-1:0] address;
    logic                readWriteMode;
    logic [dataBits-1:0] dataOut;
    logic [dataBits-1:0] dataIn;

    modport master (
        output address,
        output readWriteMode,
        output dataIn,
        input  dataOut
    );

    modport slave (
        input  address,
        input  readWriteMode,
        input  dataIn,
        output dataOut
    );

endinterface

// File: rtl/channel_send.sv
// Transmit side of the channel rendezvous: hands the message to a parked
// receiver, or parks the message and sender pid in the channel words.
module channel_send
    import channel_send_pkg::*;
#(
    parameter int addrBits = ADDRESS_BITS,
    parameter int dataBits = DATA_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                finished,
    channel_send_if.master      ram,
    input  logic [addrBits-1:0] channel,
    input  logic [addrBits-1:0] txPid,
    input  logic [dataBits-1:0] message,
    output logic                shouldScheduleReceiver,
    output logic                shouldDescheduleSender,
    output logic [addrBits-1:0] scheduleRxPid,
    output logic                hasDeliveredMessage,
    output logic [dataBits-1:0] deliveredMessage
);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        READ       = 4'd1,
        HANDLE     = 4'd2,
        CLEAR_0    = 4'd3,
        CLEAR_1    = 4'd4,
        PARK_MSG_0 = 4'd5,
        PARK_MSG_1 = 4'd6,
        PARK_PID_0 = 4'd7,
        PARK_PID_1 = 4'd8
    } state_e;

    state_e state, nextState;

    logic [addrBits-1:0] channelReg;
    logic [addrBits-1:0] txPidReg;
    logic [dataBits-1:0] messageReg;

    logic [addrBits-1:0] pidAddr;
    logic [addrBits-1:0] msgAddr;
    logic                rxWaiting;

    // Only the low addrBits of the channel word carry the pid.
    logic unusedPidHighBits;
    assign unusedPidHighBits = ^ram.dataOut[dataBits-1:addrBits];

    // Message address wraps naturally at the top of the address space.
    assign pidAddr   = channelReg + addrBits'(CHANNEL_PID_OFFSET);
    assign msgAddr   = channelReg + addrBits'(CHANNEL_MSG_OFFSET);
    assign rxWaiting = (scheduleRxPid != addrBits'(NO_PROCESS));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState         = state;
        ram.address       = pidAddr;
        ram.readWriteMode = RAM_READ;
        ram.dataIn        = '0;
        case (state)
            IDLE: begin
                ram.address = channel + addrBits'(CHANNEL_PID_OFFSET);
                if (start) begin
                    nextState = READ;
                end
            end
            READ: begin
                nextState = HANDLE;
            end
            HANDLE: begin
                nextState = rxWaiting ? CLEAR_0 : PARK_MSG_0;
            end
            CLEAR_0, CLEAR_1: begin
                ram.readWriteMode = RAM_WRITE;
                ram.dataIn        = dataBits'(NO_PROCESS);
                nextState         = (state == CLEAR_0) ? CLEAR_1 : IDLE;
            end
            PARK_MSG_0, PARK_MSG_1: begin
                ram.address       = msgAddr;
                ram.readWriteMode = RAM_WRITE;
                ram.dataIn        = messageReg;
                nextState         = (state == PARK_MSG_0) ? PARK_MSG_1 : PARK_PID_0;
            end
            PARK_PID_0, PARK_PID_1: begin
                ram.readWriteMode = RAM_WRITE;
                ram.dataIn        = dataBits'(txPidReg);
                nextState         = (state == PARK_PID_0) ? PARK_PID_1 : IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
        // An abort must not let the in-flight write land.
        if (reset) begin
            ram.readWriteMode = RAM_READ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            finished               <= 1'b0;
            shouldScheduleReceiver <= 1'b0;
            shouldDescheduleSender <= 1'b0;
            hasDeliveredMessage    <= 1'b0;
            scheduleRxPid          <= '0;
            deliveredMessage       <= '0;
        end else begin
            finished <= (state == CLEAR_1) || (state == PARK_PID_1);
            case (state)
                IDLE: begin
                    if (start) begin
                        channelReg             <= channel;
                        txPidReg               <= txPid;
                        messageReg             <= message;
                        shouldScheduleReceiver <= 1'b0;
                        shouldDescheduleSender <= 1'b0;
                        hasDeliveredMessage    <= 1'b0;
                    end
                end
                READ: begin
                    scheduleRxPid <= ram.dataOut[addrBits-1:0];
                end
                HANDLE: begin
                    shouldScheduleReceiver <= rxWaiting;
                    hasDeliveredMessage    <= rxWaiting;
                    shouldDescheduleSender <= !rxWaiting;
                    if (rxWaiting) begin
                        deliveredMessage <= messageReg;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_channel_send.sv
// Bench for channel_send: RAM model, transaction-level reference model with a
// per-cycle compare thread, and directed vectors with literal expectations.
module tb_channel_send;
    import channel_send_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] channel = '0;
    logic [AW-1:0] txPid = '0;
    logic [DW-1:0] message = '0;
    logic          busy, finished;
    logic          shouldScheduleReceiver, shouldDescheduleSender, hasDeliveredMessage;
    logic [AW-1:0] scheduleRxPid;
    logic [DW-1:0] deliveredMessage;

    int checks = 0;
    int errors = 0;

    channel_send_if #(.addrBits(AW), .dataBits(DW)) bus ();

    channel_send #(.addrBits(AW), .dataBits(DW)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .busy                   (busy),
        .finished               (finished),
        .ram                    (bus),
        .channel                (channel),
        .txPid                  (txPid),
        .message                (message),
        .shouldScheduleReceiver (shouldScheduleReceiver),
        .shouldDescheduleSender (shouldDescheduleSender),
        .scheduleRxPid          (scheduleRxPid),
        .hasDeliveredMessage    (hasDeliveredMessage),
        .deliveredMessage       (deliveredMessage)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM plus a preload port for the bench.
    logic [DW-1:0] mem [0:255] = '{default: '0};
    logic          preEn = 1'b0;
    logic [AW-1:0] preAddr = '0;
    logic [DW-1:0] preData = '0;

    always @(posedge clk) begin
        if (preEn) mem[preAddr] <= preData;
        else if (bus.readWriteMode == RAM_WRITE) mem[bus.address] <= bus.dataIn;
        bus.dataOut <= mem[bus.address];
    end

    // Reference model: whole-transaction effect on a shadow RAM, outputs
    // released according to the documented latencies.
    logic [DW-1:0] shadow [0:255] = '{default: '0};
    bit            mReady = 1'b0;
    bit            mBusy = 1'b0;
    int            mAge = 0;
    int            mLen = 0;
    logic [AW-1:0] mCh = '0, mMsgAddr = '0, mPid = '0;
    logic [DW-1:0] mMsg = '0;
    bit            expFinished = 1'b0, expSched = 1'b0, expDesched = 1'b0, expDel = 1'b0;
    logic [AW-1:0] expRxPid = '0;
    logic [DW-1:0] expDelMsg = '0;

    always @(posedge clk) begin
        if (preEn) shadow[preAddr] = preData;
        expFinished = 1'b0;
        if (reset) begin
            mReady = 1'b1;
            mBusy = 1'b0;
            expSched = 1'b0;
            expDesched = 1'b0;
            expDel = 1'b0;
            expRxPid = '0;
            expDelMsg = '0;
        end else if (mBusy) begin
            mAge++;
            if (mAge == 1) expRxPid = mPid;
            if (mAge == 2) begin
                expSched = (mPid != 0);
                expDel = (mPid != 0);
                expDesched = (mPid == 0);
                if (mPid != 0) expDelMsg = mMsg;
            end
            if (mAge == mLen) begin
                mBusy = 1'b0;
                expFinished = 1'b1;
            end
        end else if (start) begin
            assert (txPid != '0) else $error("precondition violated: txPid is zero");
            mCh = channel;
            mMsgAddr = channel + 8'd1;
            mMsg = message;
            mPid = shadow[channel][AW-1:0];
            expSched = 1'b0;
            expDesched = 1'b0;
            expDel = 1'b0;
            mBusy = 1'b1;
            mAge = 0;
            if (mPid != 0) begin
                mLen = 4;
                shadow[mCh] = '0;
            end else begin
                mLen = 6;
                shadow[mMsgAddr] = mMsg;
                shadow[mCh] = {8'h00, txPid};
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareLoop();
        forever begin
            @(negedge clk);
            if (mReady) begin
                check("busy", busy, mBusy);
                check("finished", finished, expFinished);
                check("shouldScheduleReceiver", shouldScheduleReceiver, expSched);
                check("shouldDescheduleSender", shouldDescheduleSender, expDesched);
                check("hasDeliveredMessage", hasDeliveredMessage, expDel);
                check("scheduleRxPid", scheduleRxPid, expRxPid);
                check("deliveredMessage", deliveredMessage, expDelMsg);
                check("oneFlagOnly", shouldScheduleReceiver & shouldDescheduleSender, 0);
                if (expFinished) begin
                    check("ramPidWord", mem[mCh], shadow[mCh]);
                    check("ramMsgWord", mem[mMsgAddr], shadow[mMsgAddr]);
                end
            end
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        preEn = 1'b1;
        preAddr = a;
        preData = d;
        @(negedge clk);
        preEn = 1'b0;
    endtask

    // Returns the cycle index (start cycle = 0) at which finished was seen.
    task automatic runOp(input logic [AW-1:0] ch, input logic [AW-1:0] pid,
                         input logic [DW-1:0] msg, input int retrigA, input int retrigB,
                         output int lat);
        channel = ch;
        txPid = pid;
        message = msg;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!finished && lat < 20) begin
            if (lat == retrigA || lat == retrigB) begin
                channel = ch + 8'h40;
                start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
    endtask

    int lat;
    int extraPulses;

    initial begin
        fork
            compareLoop();
        join_none

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("resetBusy", busy, 0);
        check("resetFinished", finished, 0);
        check("resetRxPid", scheduleRxPid, 0);
        check("resetDelivered", deliveredMessage, 0);

        // Empty channel: park path.
        preload(8'h10, 16'h0000);
        preload(8'h11, 16'h0000);
        runOp(8'h10, 8'h05, 16'hBEEF, -1, -1, lat);
        check("parkLatency", lat, 7);
        check("parkMsgWord", mem[8'h11], 16'hBEEF);
        check("parkPidWord", mem[8'h10], 16'h0005);
        check("parkDesched", shouldDescheduleSender, 1);
        check("parkSched", shouldScheduleReceiver, 0);
        check("parkDelivered", hasDeliveredMessage, 0);

        // Receiver waiting: rendezvous path.
        preload(8'h20, 16'h0007);
        preload(8'h21, 16'h4444);
        runOp(8'h20, 8'h09, 16'h1234, -1, -1, lat);
        check("rdvLatency", lat, 5);
        check("rdvRxPid", scheduleRxPid, 8'h07);
        check("rdvSched", shouldScheduleReceiver, 1);
        check("rdvDelivered", hasDeliveredMessage, 1);
        check("rdvMessage", deliveredMessage, 16'h1234);
        check("rdvDesched", shouldDescheduleSender, 0);
        check("rdvPidCleared", mem[8'h20], 16'h0000);
        check("rdvMsgUntouched", mem[8'h21], 16'h4444);

        // Channel at the top address: message word wraps to address 0.
        preload(8'hFF, 16'h0000);
        preload(8'h00, 16'h1111);
        runOp(8'hFF, 8'h0A, 16'hCAFE, -1, -1, lat);
        check("wrapLatency", lat, 7);
        check("wrapMsgWord", mem[8'h00], 16'hCAFE);
        check("wrapPidWord", mem[8'hFF], 16'h000A);

        // Starts while busy are ignored; a start on the finished cycle is taken.
        preload(8'h30, 16'h0000);
        preload(8'h31, 16'h0000);
        preload(8'h60, 16'h000B);
        preload(8'h61, 16'h0000);
        runOp(8'h30, 8'h0C, 16'h5A5A, 2, 4, lat);
        check("retrigLatency", lat, 7);
        check("retrigIgnoredCh", mem[8'h70], 16'h0000);
        runOp(8'h60, 8'h0D, 16'h0F0F, -1, -1, lat);
        check("b2bLatency", lat, 5);
        check("b2bRxPid", scheduleRxPid, 8'h0B);
        check("b2bMessage", deliveredMessage, 16'h0F0F);
        extraPulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (finished) extraPulses++;
        end
        check("noExtraFinished", extraPulses, 0);

        // High bits of the channel word are not part of the pid.
        preload(8'h50, 16'hAB03);
        preload(8'h51, 16'h2222);
        runOp(8'h50, 8'h0E, 16'h7777, -1, -1, lat);
        check("garbageLatency", lat, 5);
        check("garbageRxPid", scheduleRxPid, 8'h03);
        check("garbageSched", shouldScheduleReceiver, 1);
        check("garbageMsgUntouched", mem[8'h51], 16'h2222);

        // Reset during cycle 4 of a park aborts before the pid is written.
        preload(8'h10, 16'h0000);
        preload(8'h11, 16'h0000);
        channel = 8'h10;
        txPid = 8'h06;
        message = 16'h5555;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abortBusy", busy, 0);
        check("abortFinished", finished, 0);
        check("abortDesched", shouldDescheduleSender, 0);
        check("abortRxPid", scheduleRxPid, 0);
        check("abortDelivered", deliveredMessage, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("abortPidWord", mem[8'h10], 16'h0000);
        check("abortIdle", busy, 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
